// File: rtl/param_delay_line.sv
// Parameterised delay line: DEPTH stages of WIDTH-bit data plus a valid flag,
// with hold (en), synchronous flush, and a combinational tap port that reads
// any stage.
// Optional feature: define DELAY_LINE_COUNT_EN to add the occupancy port and
// its up/down counter of valid stages.
module param_delay_line #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic [SELW-1:0]  tap_sel,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid
`ifdef DELAY_LINE_COUNT_EN
    ,
    output logic [CNTW-1:0]  occupancy
`endif
);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];

    // Next state of each stage: flush clears everything, en shifts, otherwise hold.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end
        end else if (en) begin
            data_d[0]  = d_valid ? d : '0;
            valid_d[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= data_d[i];
                valid_q[i] <= valid_d[i];
            end
        end
    end

    // The output is the last stage register itself, so there is no path from the inputs.
    assign q       = data_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];

    // Tap mux: an index that matches no existing stage reads as zero.
    always_comb begin
        tap_q     = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == SELW'(i)) begin
                tap_q     = data_q[i];
                tap_valid = valid_q[i];
            end
        end
    end

`ifdef DELAY_LINE_COUNT_EN
    logic [CNTW-1:0] occ_q;
    logic [CNTW-1:0] occ_d;
    logic            beat_in;
    logic            beat_out;

    // Count valid stages: a beat entering and one leaving on the same edge cancel out.
    always_comb begin
        beat_in  = en && d_valid;
        beat_out = en && valid_q[DEPTH-1];
        occ_d    = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (beat_in && !beat_out) begin
            occ_d = occ_q + CNTW'(1);
        end else if (!beat_in && beat_out) begin
            occ_d = occ_q - CNTW'(1);
        end
    end

    // Occupancy register, cleared together with the stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
